// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Covers the bus geometry and the grant FSM state encoding.
package data_mem_responder_pkg;

    localparam int WORD_WIDTH   = 32;
    localparam int MEM_BE_WIDTH = 4;

    typedef enum logic [0:0] {
        RS_IDLE = 1'b0,
        RS_WAIT = 1'b1
    } resp_state_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// Core data-memory req/gnt/rvalid bus.
// The master modport is the core side and the slave modport is the memory side.
interface data_mem_responder_if;
    import data_mem_responder_pkg::*;

    logic                    req;
    logic [31:0]             addr;
    logic                    we;
    logic [MEM_BE_WIDTH-1:0] be;
    logic [WORD_WIDTH-1:0]   wdata;
    logic                    gnt;
    logic                    rvalid;
    logic [WORD_WIDTH-1:0]   rdata;
    logic                    err;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata, err
    );

endinterface

// File: rtl/data_mem_responder_resp_delay_line.sv
// Fixed-latency response pipe carrying {valid, err, rdata}.
// Every stage is cleared asynchronously so that a reset drops in-flight responses.
module resp_delay_line #(
    parameter int STAGES = 1,
    parameter int DATA_W = 34
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_stage [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/data_mem_responder.sv
// Word-organised SRAM responder for the core data port.
// It applies a programmable grant stall, byte-lane writes, a range check and a fixed response latency.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int MEM_DEPTH  = 1024,
    parameter int GNT_WAIT   = 0,
    parameter int RVALID_LAT = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    data_mem_responder_if.slave bus
);

    localparam int AW     = $clog2(MEM_DEPTH);
    localparam int RESP_W = WORD_WIDTH + 2;

    resp_state_e             r_state;
    resp_state_e             w_state_nxt;
    logic [3:0]              r_cnt;
    logic [3:0]              w_cnt_nxt;
    logic                    w_gnt_fsm;
    logic                    w_gnt;
    logic [WORD_WIDTH-1:0]   r_mem [MEM_DEPTH];
    logic [AW-1:0]           w_word_idx;
    logic                    w_oor;
    logic [WORD_WIDTH-1:0]   w_resp_data;
    logic [RESP_W-1:0]       w_resp_in;
    logic [RESP_W-1:0]       w_resp_out;

    assign w_word_idx = bus.addr[AW+1:2];
    assign w_oor      = |bus.addr[31:AW+2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RS_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Grant arrives on the (GNT_WAIT+1)-th consecutive request cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gnt_fsm   = 1'b0;
        case (r_state)
            RS_IDLE: begin
                if (bus.req) begin
                    if (GNT_WAIT == 0) begin
                        w_gnt_fsm = 1'b1;
                    end else begin
                        w_state_nxt = RS_WAIT;
                        w_cnt_nxt   = 4'd1;
                    end
                end
            end
            RS_WAIT: begin
                if (!bus.req) begin
                    w_state_nxt = RS_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == 4'(GNT_WAIT)) begin
                    w_gnt_fsm   = 1'b1;
                    w_state_nxt = RS_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = RS_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Masked by reset so that no grant or write can leak through while rst_n is low.
    assign w_gnt   = w_gnt_fsm & rst_n;
    assign bus.gnt = w_gnt;

    always_ff @(posedge clk) begin
        if (w_gnt && bus.we && !w_oor) begin
            for (int k = 0; k < MEM_BE_WIDTH; k++) begin
                if (bus.be[k]) begin
                    r_mem[w_word_idx][8*k +: 8] <= bus.wdata[8*k +: 8];
                end
            end
        end
    end

    // Writes and out-of-range accesses respond with zero data.
    assign w_resp_data = (bus.we || w_oor) ? '0 : r_mem[w_word_idx];
    assign w_resp_in   = w_gnt ? {1'b1, w_oor, w_resp_data} : '0;

    resp_delay_line #(
        .STAGES (RVALID_LAT),
        .DATA_W (RESP_W)
    ) u_resp_delay_line (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (w_resp_in),
        .o_q   (w_resp_out)
    );

    assign bus.rvalid = w_resp_out[RESP_W-1];
    assign bus.err    = w_resp_out[RESP_W-2];
    assign bus.rdata  = w_resp_out[WORD_WIDTH-1:0];

endmodule
